// File: rtl/bcd_to_b16_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

    localparam int NDIG  = 5;
    localparam int ACC_W = 17;
    localparam int IDX_W = $clog2(NDIG);
    localparam int SR_W  = 4 * NDIG;

    localparam logic [ACC_W-1:0] B16_MAX       = 17'd65535;
    localparam logic [3:0]       BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    function automatic logic is_bad_digit(input logic [3:0] d);
        return d > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_to_b16_if.sv
// Handshake and data bundle between the digit source and the converter.
interface bcd_to_b16_if;

    logic        start;
    logic        enable;
    logic [3:0]  D5;
    logic [3:0]  D4;
    logic [3:0]  D3;
    logic [3:0]  D2;
    logic [3:0]  D1;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow;
    logic        bad_digit;

    modport master (
        output start, enable, D5, D4, D3, D2, D1,
        input  busy, done, result, overflow, bad_digit
    );

    modport slave (
        input  start, enable, D5, D4, D3, D2, D1,
        output busy, done, result, overflow, bad_digit
    );

endinterface

// File: rtl/bcd_to_b16_mac10.sv
// Combinational acc*10 + digit step; *10 built from two shifts and an add.
module bcd_mac10
    import bcd_pkg::*;
(
    input  logic [ACC_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc_out
);

    assign acc_out = (acc_in << 3) + (acc_in << 1) + {{(ACC_W-4){1'b0}}, digit};

endmodule

// File: rtl/bcd_to_b16.sv
// Five-digit BCD to 16-bit binary, one digit per clock, MSD first.
// Build option BCD_TO_B16_SATURATE_EN: clamp overflowing results to 16'hFFFF.
module bcd_to_b16
    import bcd_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    bcd_to_b16_if.slave     bus
);

    state_t             state_q,    state_d;
    logic [SR_W-1:0]    sr_q,       sr_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic               bad_acc_q,  bad_acc_d;
    logic [15:0]        result_q,   result_d;
    logic               ovf_q,      ovf_d;
    logic               bad_q,      bad_d;

    logic [3:0]         digit_cur;
    logic [ACC_W-1:0]   acc_mac;
    logic               bad_now;
    logic               last_digit;

    // Digits leave the top of the shift register, so D5 is consumed first.
    assign digit_cur  = sr_q[SR_W-1 -: 4];
    assign bad_now    = bad_acc_q | is_bad_digit(digit_cur);
    assign last_digit = (idx_q == IDX_W'(NDIG - 1));

    bcd_mac10 u_mac (
        .acc_in  (acc_q),
        .digit   (digit_cur),
        .acc_out (acc_mac)
    );

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        bad_acc_d = bad_acc_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        bad_d     = bad_q;

        case (state_q)
            IDLE: begin
                if (bus.start && bus.enable) begin
                    state_d   = CONV;
                    sr_d      = {bus.D5, bus.D4, bus.D3, bus.D2, bus.D1};
                    acc_d     = '0;
                    idx_d     = '0;
                    bad_acc_d = 1'b0;
                end
            end
            CONV: begin
                acc_d     = acc_mac;
                sr_d      = {sr_q[SR_W-5:0], 4'h0};
                idx_d     = idx_q + IDX_W'(1);
                bad_acc_d = bad_now;
                if (last_digit) begin
                    state_d = DONE;
                    // A bad digit poisons the value, so overflow is not reported.
                    if (bad_now) begin
                        bad_d    = 1'b1;
                        ovf_d    = 1'b0;
                        result_d = 16'd0;
                    end else if (acc_mac > B16_MAX) begin
                        bad_d    = 1'b0;
                        ovf_d    = 1'b1;
`ifdef BCD_TO_B16_SATURATE_EN
                        result_d = 16'hFFFF;
`else
                        result_d = acc_mac[15:0];
`endif
                    end else begin
                        bad_d    = 1'b0;
                        ovf_d    = 1'b0;
                        result_d = acc_mac[15:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            bad_acc_q <= 1'b0;
            result_q  <= 16'd0;
            ovf_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            bad_acc_q <= bad_acc_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            bad_q     <= bad_d;
        end
    end

    assign bus.busy      = (state_q == CONV);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.bad_digit = bad_q;

endmodule

// File: tb/tb_bcd_to_b16.sv
// Directed bench for bcd_to_b16: conversions, flags, timing, reset abort, input isolation.
module tb_bcd_to_b16;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    bcd_to_b16_if bus ();

    bcd_to_b16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) exp %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] d5, d4, d3, d2, d1);
        bus.D5 = d5; bus.D4 = d4; bus.D3 = d3; bus.D2 = d2; bus.D1 = d1;
    endtask

    // One-cycle start pulse, then watch a fixed 20-cycle window.
    task automatic run_conv(input logic [3:0] d5, d4, d3, d2, d1,
                            output int busy_cnt, output int done_cnt, output int done_at);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        @(negedge clk);
        set_digits(d5, d4, d3, d2, d1);
        bus.enable = 1'b1;
        bus.start  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
    endtask

    int bc, dc, da;
    int d1_at, d2_at, ndone;

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.enable = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   bus.busy,      0);
        chk("rst_done",   bus.done,      0);
        chk("rst_result", bus.result,    0);
        chk("rst_ovf",    bus.overflow,  0);
        chk("rst_bad",    bus.bad_digit, 0);
        rst = 1'b0;

        // 58039
        run_conv(4'd5, 4'd8, 4'd0, 4'd3, 4'd9, bc, dc, da);
        chk("t1_busy_cycles", bc, 5);
        chk("t1_done_pulses", dc, 1);
        chk("t1_done_at",     da, 5);
        chk("t1_result",      bus.result,    16'd58039);
        chk("t1_ovf",         bus.overflow,  0);
        chk("t1_bad",         bus.bad_digit, 0);

        // 32, then start with enable low must be ignored
        run_conv(4'd0, 4'd0, 4'd0, 4'd3, 4'd2, bc, dc, da);
        chk("t2_result", bus.result, 16'd32);
        @(negedge clk);
        set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        bus.enable = 1'b0;
        bus.start  = 1'b1;
        bc = 0; dc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.busy) bc++;
            if (bus.done) dc++;
        end
        bus.start = 1'b0;
        chk("t2_en0_busy",   bc, 0);
        chk("t2_en0_done",   dc, 0);
        chk("t2_en0_result", bus.result, 16'd32);

        // Upper boundary and overflow
        run_conv(4'd6, 4'd5, 4'd5, 4'd3, 4'd5, bc, dc, da);
        chk("t3_max_result", bus.result,   16'hFFFF);
        chk("t3_max_ovf",    bus.overflow, 0);
        run_conv(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, bc, dc, da);
        chk("t3_ovf_flag",   bus.overflow, 1);
`ifdef BCD_TO_B16_SATURATE_EN
        chk("t3_ovf_result", bus.result, 16'hFFFF);
`else
        chk("t3_ovf_result", bus.result, 16'h869F);
`endif
        chk("t3_ovf_bad",    bus.bad_digit, 0);

        // Bad digit, then a valid conversion clears it
        run_conv(4'd1, 4'd1, 4'hC, 4'd1, 4'd1, bc, dc, da);
        chk("t4_bad_flag",   bus.bad_digit, 1);
        chk("t4_bad_result", bus.result,    0);
        chk("t4_bad_ovf",    bus.overflow,  0);
        chk("t4_bad_done",   dc, 1);
        run_conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd7, bc, dc, da);
        chk("t4_clr_bad",    bus.bad_digit, 0);
        chk("t4_clr_result", bus.result,    16'd7);

        // Reset during the third CONV cycle aborts with no done
        @(negedge clk);
        set_digits(4'd4, 4'd4, 4'd4, 4'd4, 4'd4);
        bus.enable = 1'b1;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy_before_rst", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_busy",   bus.busy,      0);
        chk("t5_rst_done",   bus.done,      0);
        chk("t5_rst_result", bus.result,    0);
        chk("t5_rst_ovf",    bus.overflow,  0);
        chk("t5_rst_bad",    bus.bad_digit, 0);
        dc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dc++;
        end
        chk("t5_no_activity", dc, 0);
        run_conv(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, bc, dc, da);
        chk("t5_after_result", bus.result, 16'd12345);
        chk("t5_after_done",   dc, 1);

        // Digit change after capture and a start during CONV have no effect
        @(negedge clk);
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd9);
        bus.enable = 1'b1;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.D1    = 4'd1;
        dc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = (i == 0);
            if (bus.done) dc++;
        end
        bus.start = 1'b0;
        chk("t6_result",      bus.result, 16'd12349);
        chk("t6_done_pulses", dc, 1);

        // Held start: done pulses are 7 cycles apart
        @(negedge clk);
        set_digits(4'd0, 4'd0, 4'd1, 4'd0, 4'd0);
        bus.start = 1'b1;
        d1_at = -1; d2_at = -1; ndone = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (ndone == 0) d1_at = i;
                else if (ndone == 1) d2_at = i;
                ndone++;
            end
        end
        bus.start = 1'b0;
        chk("t7_first_done", d1_at, 5);
        chk("t7_spacing",    d2_at - d1_at, 7);
        chk("t7_result",     bus.result, 16'd100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
